// File: rtl/rename_tag_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rename_tag_scheduler                                                     |
// | Allocates 3-bit dependency tags and retires them in program order, while |
// | driving the register-file commit port.                                   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rename_tag_scheduler #(
  parameter int TAG_W  = 3,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [REG_W-1:0]  issue_rd,
  output logic              issue_ready,
  output logic [TAG_W-1:0]  issue_tag,
  input  logic              wb_valid,
  input  logic [TAG_W-1:0]  wb_tag,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              rf_commit,
  output logic [REG_W-1:0]  rf_reg_num,
  output logic [DATA_W-1:0] rf_data,
  output logic [TAG_W-1:0]  rf_num,
  output logic [TAG_W-1:0]  occupancy,
  output logic              wb_err
);

  localparam int               ENTRIES   = (1 << TAG_W) - 1;
  localparam logic [TAG_W-1:0] LAST_TAG  = TAG_W'(ENTRIES);
  localparam logic [TAG_W-1:0] FIRST_TAG = TAG_W'(1);

  // Entry 0 exists only so the arrays can be indexed directly by tag.
  logic [ENTRIES:0]  busy_q, busy_d;
  logic [ENTRIES:0]  done_q, done_d;
  logic [REG_W-1:0]  rd_q   [0:ENTRIES];
  logic [REG_W-1:0]  rd_d   [0:ENTRIES];
  logic [DATA_W-1:0] data_q [0:ENTRIES];
  logic [DATA_W-1:0] data_d [0:ENTRIES];

  logic [TAG_W-1:0]  head_q, head_d;
  logic [TAG_W-1:0]  tail_q, tail_d;
  logic [TAG_W-1:0]  occ_q, occ_d;

  logic              rf_commit_q, rf_commit_d;
  logic [REG_W-1:0]  rf_reg_num_q, rf_reg_num_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;
  logic [TAG_W-1:0]  rf_num_q, rf_num_d;
  logic              wb_err_q, wb_err_d;

  logic do_issue;
  logic wb_ok;
  logic do_retire;

  function automatic logic [TAG_W-1:0] next_tag(input logic [TAG_W-1:0] t);
    return (t == LAST_TAG) ? FIRST_TAG : t + FIRST_TAG;
  endfunction

  assign issue_ready = (occ_q != LAST_TAG);
  assign issue_tag   = tail_q;

  always_comb begin
    do_issue  = issue_valid && issue_ready;
    wb_ok     = wb_valid && (wb_tag != '0) && busy_q[wb_tag] && !done_q[wb_tag];
    // Retire looks only at registered state, so a writeback lands one edge
    // before the entry can retire.
    do_retire = busy_q[head_q] && done_q[head_q];

    busy_d       = busy_q;
    done_d       = done_q;
    rd_d         = rd_q;
    data_d       = data_q;
    head_d       = head_q;
    tail_d       = tail_q;
    occ_d        = occ_q;
    rf_commit_d  = 1'b0;
    rf_reg_num_d = rf_reg_num_q;
    rf_data_d    = rf_data_q;
    rf_num_d     = rf_num_q;
    wb_err_d     = 1'b0;

    if (!rst || flush) begin
      busy_d = '0;
      done_d = '0;
      head_d = FIRST_TAG;
      tail_d = FIRST_TAG;
      occ_d  = '0;
      if (!rst) begin
        rf_reg_num_d = '0;
        rf_data_d    = '0;
        rf_num_d     = '0;
      end
    end else begin
      wb_err_d = wb_valid && !wb_ok;
      if (wb_ok) begin
        done_d[wb_tag] = 1'b1;
        data_d[wb_tag] = wb_data;
      end
      if (do_retire) begin
        busy_d[head_q] = 1'b0;
        done_d[head_q] = 1'b0;
        rf_commit_d    = (rd_q[head_q] != '0);
        rf_reg_num_d   = rd_q[head_q];
        rf_data_d      = data_q[head_q];
        rf_num_d       = head_q;
        head_d         = next_tag(head_q);
      end
      // A full queue blocks issue, so tail never collides with a retiring head.
      if (do_issue) begin
        busy_d[tail_q] = 1'b1;
        done_d[tail_q] = 1'b0;
        rd_d[tail_q]   = issue_rd;
        tail_d         = next_tag(tail_q);
      end
      occ_d = occ_q + TAG_W'(do_issue) - TAG_W'(do_retire);
    end
  end

  always_ff @(posedge clk) begin
    busy_q       <= busy_d;
    done_q       <= done_d;
    rd_q         <= rd_d;
    data_q       <= data_d;
    head_q       <= head_d;
    tail_q       <= tail_d;
    occ_q        <= occ_d;
    rf_commit_q  <= rf_commit_d;
    rf_reg_num_q <= rf_reg_num_d;
    rf_data_q    <= rf_data_d;
    rf_num_q     <= rf_num_d;
    wb_err_q     <= wb_err_d;
  end

  assign rf_commit  = rf_commit_q;
  assign rf_reg_num = rf_reg_num_q;
  assign rf_data    = rf_data_q;
  assign rf_num     = rf_num_q;
  assign occupancy  = occ_q;
  assign wb_err     = wb_err_q;

endmodule
`default_nettype wire

// File: tb/tb_rename_tag_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rename_tag_scheduler                                                  |
// | Directed scenarios plus randomized traffic against a program-order queue |
// | model of the tag scheduler.                                              |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_rename_tag_scheduler;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic [2:0]  issue_tag;
  logic        wb_valid;
  logic [2:0]  wb_tag;
  logic [31:0] wb_data;
  logic        flush;
  logic        rf_commit;
  logic [4:0]  rf_reg_num;
  logic [31:0] rf_data;
  logic [2:0]  rf_num;
  logic [2:0]  occupancy;
  logic        wb_err;

  rename_tag_scheduler #(.TAG_W(3), .DATA_W(32), .REG_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .issue_tag   (issue_tag),
    .wb_valid    (wb_valid),
    .wb_tag      (wb_tag),
    .wb_data     (wb_data),
    .flush       (flush),
    .rf_commit   (rf_commit),
    .rf_reg_num  (rf_reg_num),
    .rf_data     (rf_data),
    .rf_num      (rf_num),
    .occupancy   (occupancy),
    .wb_err      (wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: in-flight instructions in program order.
  typedef struct {
    logic [2:0]  tag;
    logic [4:0]  rd;
    bit          done;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  logic [2:0]  m_next = 3'd1;
  logic        e_commit = 1'b0;
  logic [4:0]  e_reg = '0;
  logic [31:0] e_data = '0;
  logic [2:0]  e_num = '0;
  logic        e_err = 1'b0;

  // Values seen on the combinational issue outputs before the edge, and the
  // model's prediction of them.
  logic        seen_ready, pre_ready;
  logic [2:0]  seen_tag, pre_tag;

  task automatic model_edge(input logic iv, input logic [4:0] ird, input logic wv,
                            input logic [2:0] wt, input logic [31:0] wd,
                            input logic fl, input logic r);
    bit   ret;
    bit   found;
    int   sz;
    ent_t h;
    if (!r || fl) begin
      mq.delete();
      m_next   = 3'd1;
      e_commit = 1'b0;
      e_err    = 1'b0;
      if (!r) begin
        e_reg  = '0;
        e_data = '0;
        e_num  = '0;
      end
    end else begin
      sz    = mq.size();
      ret   = (sz > 0) && mq[0].done;
      found = 0;
      if (wv && wt != 3'd0) begin
        for (int i = 0; i < mq.size(); i++) begin
          if (mq[i].tag == wt && !mq[i].done) begin
            mq[i].done = 1;
            mq[i].data = wd;
            found      = 1;
          end
        end
      end
      e_err    = wv && !found;
      e_commit = 1'b0;
      if (ret) begin
        h        = mq.pop_front();
        e_commit = (h.rd != 5'd0);
        e_reg    = h.rd;
        e_data   = h.data;
        e_num    = h.tag;
      end
      if (iv && sz < 7) begin
        h.tag  = m_next;
        h.rd   = ird;
        h.done = 0;
        h.data = '0;
        mq.push_back(h);
        m_next = (m_next == 3'd7) ? 3'd1 : m_next + 3'd1;
      end
    end
  endtask

  // Called at a falling edge: drive inputs, capture issue outputs, cross the
  // rising edge, update the model, return at the next falling edge.
  task automatic step(input logic iv, input logic [4:0] ird, input logic wv,
                      input logic [2:0] wt, input logic [31:0] wd,
                      input logic fl, input logic r);
    issue_valid = iv;
    issue_rd    = ird;
    wb_valid    = wv;
    wb_tag      = wt;
    wb_data     = wd;
    flush       = fl;
    rst         = r;
    #1;
    seen_ready = issue_ready;
    seen_tag   = issue_tag;
    pre_ready  = (mq.size() < 7);
    pre_tag    = m_next;
    @(posedge clk);
    model_edge(iv, ird, wv, wt, wd, fl, r);
    @(negedge clk);
  endtask

  task automatic idle();                         step(0, 0, 0, 0, 0, 0, 1); endtask
  task automatic do_issue(input logic [4:0] rd); step(1, rd, 0, 0, 0, 0, 1); endtask
  task automatic do_wb(input logic [2:0] t, input logic [31:0] d); step(0, 0, 1, t, d, 0, 1); endtask
  task automatic do_flush();                     step(0, 0, 0, 0, 0, 1, 1); endtask

  task automatic test_reset();
    step(1, 5'd3, 1, 3'd2, 32'h1234, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    checks++; if (rf_commit !== 1'b0) begin errors++; $display("FAIL reset_commit got=%0b exp=0", rf_commit); end
    checks++; if (rf_reg_num !== 5'd0) begin errors++; $display("FAIL reset_reg got=%0d exp=0", rf_reg_num); end
    checks++; if (rf_data !== 32'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", rf_data); end
    checks++; if (rf_num !== 3'd0) begin errors++; $display("FAIL reset_num got=%0d exp=0", rf_num); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL reset_wb_err got=%0b exp=0", wb_err); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", issue_ready); end
    checks++; if (issue_tag !== 3'd1) begin errors++; $display("FAIL reset_tag got=%0d exp=1", issue_tag); end
    idle();
  endtask

  task automatic test_single_path();
    do_issue(5'd5);
    checks++; if (seen_tag !== 3'd1) begin errors++; $display("FAIL single_tag got=%0d exp=1", seen_tag); end
    checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL single_occ1 got=%0d exp=1", occupancy); end
    do_wb(3'd1, 32'hDEADBEEF);
    checks++; if (rf_commit !== 1'b0) begin errors++; $display("FAIL single_early got=%0b exp=0", rf_commit); end
    idle();
    checks++; if (rf_commit !== 1'b1) begin errors++; $display("FAIL single_commit got=%0b exp=1", rf_commit); end
    checks++; if (rf_reg_num !== 5'd5) begin errors++; $display("FAIL single_reg got=%0d exp=5", rf_reg_num); end
    checks++; if (rf_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data got=%h exp=deadbeef", rf_data); end
    checks++; if (rf_num !== 3'd1) begin errors++; $display("FAIL single_num got=%0d exp=1", rf_num); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL single_occ0 got=%0d exp=0", occupancy); end
    idle();
    checks++; if (rf_commit !== 1'b0) begin errors++; $display("FAIL single_pulse got=%0b exp=0", rf_commit); end
  endtask

  task automatic test_full_wrap();
    do_flush();
    for (int i = 0; i < 7; i++) begin
      do_issue(5'(i + 1));
      checks++;
      if (seen_tag !== 3'(i + 1) || seen_ready !== 1'b1) begin
        errors++; $display("FAIL full_tag%0d got=%0d/%0b exp=%0d/1", i, seen_tag, seen_ready, i + 1);
      end
    end
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%0b exp=0", issue_ready); end
    checks++; if (occupancy !== 3'd7) begin errors++; $display("FAIL full_occ got=%0d exp=7", occupancy); end
    do_issue(5'd9);
    checks++; if (seen_ready !== 1'b0 || occupancy !== 3'd7) begin
      errors++; $display("FAIL full_8th got=ready%0b/occ%0d exp=ready0/occ7", seen_ready, occupancy);
    end
    do_wb(3'd1, 32'h11);
    idle();
    checks++; if (rf_commit !== 1'b1 || rf_num !== 3'd1 || rf_reg_num !== 5'd1) begin
      errors++; $display("FAIL full_retire got=c%0b n%0d r%0d exp=c1 n1 r1", rf_commit, rf_num, rf_reg_num);
    end
    checks++; if (occupancy !== 3'd6) begin errors++; $display("FAIL full_occ6 got=%0d exp=6", occupancy); end
    do_issue(5'd10);
    checks++; if (seen_tag !== 3'd1 || seen_ready !== 1'b1) begin
      errors++; $display("FAIL wrap_tag got=%0d/%0b exp=1/1", seen_tag, seen_ready);
    end
    checks++; if (occupancy !== 3'd7) begin errors++; $display("FAIL wrap_occ got=%0d exp=7", occupancy); end
    do_flush();
  endtask

  task automatic test_out_of_order();
    do_flush();
    do_issue(5'd11);
    do_issue(5'd12);
    do_issue(5'd13);
    do_wb(3'd3, 32'h333);
    checks++; if (rf_commit !== 1'b0) begin errors++; $display("FAIL ooo_wb3 got=%0b exp=0", rf_commit); end
    do_wb(3'd2, 32'h222);
    checks++; if (rf_commit !== 1'b0) begin errors++; $display("FAIL ooo_wb2 got=%0b exp=0", rf_commit); end
    do_wb(3'd1, 32'h111);
    checks++; if (rf_commit !== 1'b0) begin errors++; $display("FAIL ooo_wb1 got=%0b exp=0", rf_commit); end
    for (int i = 1; i <= 3; i++) begin
      idle();
      checks++;
      if (rf_commit !== 1'b1 || rf_num !== 3'(i) || rf_reg_num !== 5'(10 + i) || rf_data !== 32'(i * 32'h111)) begin
        errors++; $display("FAIL ooo_commit%0d got=c%0b n%0d r%0d d%h exp=c1 n%0d r%0d d%h",
                          i, rf_commit, rf_num, rf_reg_num, rf_data, i, 10 + i, i * 32'h111);
      end
    end
    idle();
    checks++; if (rf_commit !== 1'b0 || occupancy !== 3'd0) begin
      errors++; $display("FAIL ooo_done got=c%0b occ%0d exp=c0 occ0", rf_commit, occupancy);
    end
  endtask

  task automatic test_rd_zero();
    do_flush();
    do_issue(5'd0);
    do_wb(3'd1, 32'hABCD);
    idle();
    checks++; if (rf_commit !== 1'b0) begin errors++; $display("FAIL rd0_commit got=%0b exp=0", rf_commit); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL rd0_occ got=%0d exp=0", occupancy); end
    do_wb(3'd1, 32'hABCD);
    checks++; if (wb_err !== 1'b1) begin errors++; $display("FAIL rd0_err got=%0b exp=1", wb_err); end
    idle();
    checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL rd0_err_pulse got=%0b exp=0", wb_err); end
  endtask

  task automatic test_flush_mid_flight();
    do_flush();
    for (int i = 0; i < 4; i++) do_issue(5'(20 + i));
    do_wb(3'd1, 32'h55);
    step(1, 5'd30, 1, 3'd2, 32'h66, 1, 1);
    checks++; if (occupancy !== 3'd0 || issue_tag !== 3'd1 || issue_ready !== 1'b1) begin
      errors++; $display("FAIL flush_state got=occ%0d tag%0d rdy%0b exp=occ0 tag1 rdy1", occupancy, issue_tag, issue_ready);
    end
    checks++; if (rf_commit !== 1'b0 || wb_err !== 1'b0) begin
      errors++; $display("FAIL flush_outputs got=c%0b e%0b exp=c0 e0", rf_commit, wb_err);
    end
    idle();
    idle();
    checks++; if (rf_commit !== 1'b0) begin errors++; $display("FAIL flush_late_commit got=%0b exp=0", rf_commit); end
    do_wb(3'd3, 32'h77);
    checks++; if (wb_err !== 1'b1) begin errors++; $display("FAIL flush_wb_err got=%0b exp=1", wb_err); end
    idle();
    checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL flush_err_pulse got=%0b exp=0", wb_err); end
  endtask

  task automatic test_random();
    logic        iv, wv, fl, r;
    logic [4:0]  ird;
    logic [2:0]  wt;
    logic [31:0] wd;
    int          bad;
    for (int n = 0; n < 400; n++) begin
      iv  = ($urandom_range(9) < 6);
      ird = 5'($urandom_range(31));
      wv  = ($urandom_range(1) == 1);
      if (mq.size() > 0 && $urandom_range(3) != 0)
        wt = mq[$urandom_range(mq.size() - 1)].tag;
      else
        wt = 3'($urandom_range(7));
      wd  = $urandom();
      fl  = ($urandom_range(49) == 0);
      r   = ($urandom_range(99) != 0);
      step(iv, ird, wv, wt, wd, fl, r);
      bad = 0;
      checks++;
      if (seen_ready !== pre_ready || seen_tag !== pre_tag) begin
        errors++; bad++;
        $display("FAIL rand_issue cyc=%0d got=rdy%0b tag%0d exp=rdy%0b tag%0d", n, seen_ready, seen_tag, pre_ready, pre_tag);
      end
      checks++;
      if (rf_commit !== e_commit || wb_err !== e_err || occupancy !== 3'(mq.size())) begin
        errors++; bad++;
        $display("FAIL rand_ctrl cyc=%0d got=c%0b e%0b occ%0d exp=c%0b e%0b occ%0d",
                 n, rf_commit, wb_err, occupancy, e_commit, e_err, mq.size());
      end
      checks++;
      if (rf_reg_num !== e_reg || rf_data !== e_data || rf_num !== e_num) begin
        errors++; bad++;
        $display("FAIL rand_port cyc=%0d got=r%0d d%h n%0d exp=r%0d d%h n%0d",
                 n, rf_reg_num, rf_data, rf_num, e_reg, e_data, e_num);
      end
      if (bad != 0 && errors > 20) break;
    end
  endtask

  initial begin
    rst         = 1'b0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    wb_valid    = 1'b0;
    wb_tag      = '0;
    wb_data     = '0;
    flush       = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_path();
    test_full_wrap();
    test_out_of_order();
    test_rd_zero();
    test_flush_mid_flight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
